// File: rtl/toggle_period_meter_if.sv
// toggle_period_meter_if: control, threshold and result signals of the toggle period meter
interface toggle_period_meter_if #(
  parameter int CNT_W = 32
);
  logic enable;
  logic i_toggle;
  logic [CNT_W-1:0] i_cnt_th;
  logic [CNT_W-1:0] i_tol;
  logic [CNT_W-1:0] o_half_period;
  logic o_valid;
  logic o_match;
  logic o_locked;
  logic o_timeout;
  modport master (
    output enable, i_toggle, i_cnt_th, i_tol,
    input o_half_period, o_valid, o_match, o_locked, o_timeout
  );
  modport slave (
    input enable, i_toggle, i_cnt_th, i_tol,
    output o_half_period, o_valid, o_match, o_locked, o_timeout
  );
endinterface

// File: rtl/toggle_period_meter.sv
// toggle_period_meter: measures toggle half-period in clk cycles, flags tolerance match, lock and timeout
module toggle_period_meter #(
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 500000000
) (
  input logic clk,
  input logic reset_n,
  toggle_period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, edge_det, tmo_hit, arm_hit, meas, tmo, in_tol, valid, match, timeout;
  logic [CNT_W-1:0] cnt, half, diff;
  logic [1:0] streak;
  assign edge_det = sync[SYNC_STAGES-1] ^ hist;
  assign tmo_hit = (CNT_W+32)'(cnt) == (CNT_W+32)'(TIMEOUT);
  assign diff = cnt > bus.i_cnt_th ? cnt - bus.i_cnt_th : bus.i_cnt_th - cnt;
  assign in_tol = diff <= bus.i_tol;
  assign bus.o_half_period = half;
  assign bus.o_valid = valid;
  assign bus.o_match = match;
  assign bus.o_locked = streak == 2'd2;
  assign bus.o_timeout = timeout;
  always_ff @(posedge clk) begin
    state <= !reset_n ? IDLE : nxt;
  end
  always_comb begin
    arm_hit = bus.enable && state == ARM && edge_det;
    meas = bus.enable && state == MEASURE && edge_det;
    tmo = bus.enable && state == MEASURE && !edge_det && tmo_hit;
    nxt = !bus.enable ? IDLE : state == IDLE ? ARM : arm_hit ? MEASURE : tmo ? ARM : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
      cnt <= '0;
      half <= '0;
      valid <= 1'b0;
      match <= 1'b0;
      streak <= '0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.i_toggle};
      hist <= sync[SYNC_STAGES-1];
      valid <= meas;
      half <= meas ? cnt : half;
      match <= meas ? in_tol : match;
      cnt <= nxt != MEASURE ? '0 : (arm_hit || meas) ? CNT_W'(1) : &cnt ? cnt : cnt + CNT_W'(1);
      streak <= nxt != MEASURE ? '0 : !meas ? streak : !in_tol ? '0 : streak == 2'd2 ? streak : streak + 2'd1;
      timeout <= (!bus.enable || arm_hit) ? 1'b0 : tmo ? 1'b1 : timeout;
    end
  end
endmodule

// File: tb/tb_toggle_period_meter.sv
// tb_toggle_period_meter: directed stimulus with a timestamp-based reference model for two meter configurations
module tb_toggle_period_meter;
  typedef struct {
    int mode;
    longint t_last;
    logic [2:0] sq;
    longint half;
    bit match;
    bit valid;
    int consec;
    bit tmo;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_n, en, tog;
  logic [31:0] th, tol;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int vcnt = 0;
  int last_v = 0;
  int last_flip = 0;
  int v0;
  mdl_t m0 = '{default: 0};
  mdl_t m1 = '{default: 0};
  always #5 clk = ~clk;
  toggle_period_meter_if #(.CNT_W(32)) b0 ();
  toggle_period_meter_if #(.CNT_W(4)) b1 ();
  assign b0.enable = en;
  assign b0.i_toggle = tog;
  assign b0.i_cnt_th = th;
  assign b0.i_tol = tol;
  assign b1.enable = en;
  assign b1.i_toggle = tog;
  assign b1.i_cnt_th = th[3:0];
  assign b1.i_tol = tol[3:0];
  toggle_period_meter #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(50)) dut (
    .clk(clk), .reset_n(rst_n), .bus(b0.slave)
  );
  toggle_period_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(20)) dut_sat (
    .clk(clk), .reset_n(rst_n), .bus(b1.slave)
  );
  // mode: 0 idle, 1 waiting for arming edge, 2 measuring; time since last edge replaces a counter
  function automatic mdl_t model_step(mdl_t m, bit rn, bit e_n, bit t, longint c_th, longint c_tol,
                                      longint maxv, longint tmo, longint n);
    mdl_t r = m;
    bit e;
    longint v, d;
    if (!rn) begin
      r = '{default: 0};
      return r;
    end
    e = r.sq[1] ^ r.sq[2];
    r.sq = {r.sq[1:0], t};
    r.valid = 0;
    if (!e_n) begin
      r.mode = 0;
      r.consec = 0;
      r.tmo = 0;
    end else if (r.mode == 0) r.mode = 1;
    else if (r.mode == 1) begin
      if (e) begin
        r.mode = 2;
        r.t_last = n;
        r.tmo = 0;
      end
    end else if (e) begin
      v = n - r.t_last;
      if (v > maxv) v = maxv;
      d = v > c_th ? v - c_th : c_th - v;
      r.half = v;
      r.match = d <= c_tol;
      r.valid = 1;
      r.consec = r.match ? r.consec + 1 : 0;
      r.t_last = n;
    end else if (n - r.t_last == tmo && tmo <= maxv) begin
      r.tmo = 1;
      r.consec = 0;
      r.mode = 1;
    end
    return r;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m0 <= model_step(m0, rst_n, en, tog, longint'(th), longint'(tol), 64'hFFFF_FFFF, 50, cyc);
    m1 <= model_step(m1, rst_n, en, tog, longint'(th[3:0]), longint'(tol[3:0]), 15, 20, cyc);
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic cmp(string nm, logic v, logic [31:0] h, logic mt, logic lk, logic to, mdl_t m);
    chk({nm, ".valid"}, 64'(v), 64'(m.valid));
    chk({nm, ".half"}, 64'(h), m.half);
    chk({nm, ".match"}, 64'(mt), 64'(m.match));
    chk({nm, ".locked"}, 64'(lk), 64'(m.consec >= 2));
    chk({nm, ".timeout"}, 64'(to), 64'(m.tmo));
  endtask
  always @(negedge clk) begin
    cmp("m32", b0.o_valid, b0.o_half_period, b0.o_match, b0.o_locked, b0.o_timeout, m0);
    cmp("m4", b1.o_valid, 32'(b1.o_half_period), b1.o_match, b1.o_locked, b1.o_timeout, m1);
    if (b0.o_valid) begin
      vcnt <= vcnt + 1;
      last_v <= cyc;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    repeat (4) tick;
  endtask
  task automatic run(int per, int k);
    for (int i = 0; i < k; i++) begin
      while (cyc < last_flip + per) tick;
      tog = ~tog;
      last_flip = cyc;
    end
  endtask
  task automatic lit_zero(string nm);
    chk({nm, ".half"}, 64'(b0.o_half_period), 0);
    chk({nm, ".valid"}, 64'(b0.o_valid), 0);
    chk({nm, ".match"}, 64'(b0.o_match), 0);
    chk({nm, ".locked"}, 64'(b0.o_locked), 0);
    chk({nm, ".timeout"}, 64'(b0.o_timeout), 0);
    chk({nm, ".sat_half"}, 64'(b1.o_half_period), 0);
  endtask
  initial begin
    rst_n = 0;
    en = 0;
    tog = 0;
    th = 10;
    tol = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      tog = ~tog;
    end
    lit_zero("reset");
    rst_n = 1;
    repeat (5) tick;
    lit_zero("release");
    en = 1;
    last_flip = cyc;
    v0 = vcnt;
    run(10, 5);
    settle;
    chk("nom.half", 64'(b0.o_half_period), 10);
    chk("nom.match", 64'(b0.o_match), 1);
    chk("nom.locked", 64'(b0.o_locked), 1);
    chk("nom.nvalid", 64'(vcnt - v0), 4);
    tol = 1;
    run(12, 1);
    settle;
    chk("oot.half", 64'(b0.o_half_period), 12);
    chk("oot.match", 64'(b0.o_match), 0);
    chk("oot.locked", 64'(b0.o_locked), 0);
    run(11, 1);
    settle;
    chk("tol.half", 64'(b0.o_half_period), 11);
    chk("tol.match", 64'(b0.o_match), 1);
    chk("tol.locked1", 64'(b0.o_locked), 0);
    run(11, 1);
    settle;
    chk("tol.locked2", 64'(b0.o_locked), 1);
    for (int k = 0; k < 100 && !b0.o_timeout; k++) tick;
    chk("tmo.seen", 64'(b0.o_timeout), 1);
    chk("tmo.dist", 64'(cyc - last_v), 50);
    chk("tmo.locked", 64'(b0.o_locked), 0);
    chk("tmo.half", 64'(b0.o_half_period), 11);
    last_flip = cyc;
    v0 = vcnt;
    run(10, 1);
    settle;
    chk("rearm.timeout", 64'(b0.o_timeout), 0);
    chk("rearm.nvalid", 64'(vcnt - v0), 0);
    run(10, 1);
    settle;
    chk("resume.half", 64'(b0.o_half_period), 10);
    chk("resume.nvalid", 64'(vcnt - v0), 1);
    run(10, 1);
    repeat (8) tick;
    en = 0;
    settle;
    chk("dis.valid", 64'(b0.o_valid), 0);
    chk("dis.locked", 64'(b0.o_locked), 0);
    chk("dis.timeout", 64'(b0.o_timeout), 0);
    chk("dis.half", 64'(b0.o_half_period), 10);
    v0 = vcnt;
    en = 1;
    last_flip = cyc;
    run(10, 1);
    settle;
    chk("reen.nvalid", 64'(vcnt - v0), 0);
    run(10, 1);
    settle;
    chk("reen.nvalid2", 64'(vcnt - v0), 1);
    v0 = vcnt;
    run(10, 1);
    tick;
    tick;
    en = 0;
    settle;
    chk("disedge.nvalid", 64'(vcnt - v0), 0);
    chk("disedge.half", 64'(b0.o_half_period), 10);
    en = 1;
    last_flip = cyc;
    run(10, 2);
    settle;
    chk("disedge.rearm", 64'(vcnt - v0), 1);
    run(30, 3);
    settle;
    chk("sat.half", 64'(b1.o_half_period), 15);
    chk("sat.timeout", 64'(b1.o_timeout), 0);
    chk("wide.half", 64'(b0.o_half_period), 30);
    chk("wide.match", 64'(b0.o_match), 0);
    repeat (70) tick;
    chk("quiet.timeout", 64'(b0.o_timeout), 1);
    chk("quiet.sat_timeout", 64'(b1.o_timeout), 0);
    chk("quiet.sat_half", 64'(b1.o_half_period), 15);
    rst_n = 0;
    repeat (2) tick;
    lit_zero("midreset");
    rst_n = 1;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
- Measures the half-period of an incoming toggle waveform, e.g. one produced by the counter-toggle generators driving the board LEDs.
- Counts clk cycles between consecutive edges of the toggle signal and reports each measurement.
- Flags whether each measurement is within a tolerance of an expected threshold, and declares lock or timeout.
- Used for board self-test / loopback of toggle outputs back onto switch or GPIO inputs.

Parameters:
- CNT_W, 32: width of the counter, threshold, tolerance and result.
- SYNC_STAGES, 2: flip-flop stages in the i_toggle synchronizer, minimum 2.
- TIMEOUT, 500000000: cycles without an edge before timeout is declared.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- i_toggle  input  1  asynchronous toggle waveform under measurement.
- i_cnt_th  input  CNT_W  expected half-period in clk cycles.
- i_tol  input  CNT_W  allowed absolute deviation from i_cnt_th.
- o_half_period  output  CNT_W  last measured half-period.
- o_valid  output  1  one-cycle pulse when o_half_period/o_match update.
- o_match  output  1  last measurement within tolerance.
- o_locked  output  1  two or more consecutive matching measurements.
- o_timeout  output  1  no edge seen within TIMEOUT cycles.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low, sampled on the rising edge of clk; the port names are clk and reset_n. While reset_n=0:
  - all synchronizer flops, the edge-history flop and the counter are cleared to 0;
  - state = IDLE;
  - all outputs are 0.
- Reset mid-operation discards any measurement in progress.
- Synchronizer: SYNC_STAGES flops followed by one history flop. An edge is sync_out XOR history. The synchronizer and history flop run regardless of enable.
- Input delay is fixed at SYNC_STAGES+1 cycles, so measured intervals are unaffected.
- State machine (3 states):
  - IDLE: counter held at 0. If enable=1, go to ARM next cycle.
  - ARM: waiting for the first edge. On an edge: counter <= 1, go to MEASURE. No o_valid is produced for the arming edge.
  - MEASURE, no edge: counter <= counter+1, saturating at all-ones.
  - MEASURE, edge: o_half_period <= counter, o_valid=1 for one cycle (registered, next cycle), counter <= 1, stay in MEASURE.
- Result check: an input toggling every N cycles reports exactly N.
- Timeout: in MEASURE, when counter = TIMEOUT with no edge:
  - o_timeout <= 1, o_locked <= 0, go to ARM;
  - o_half_period and o_match are retained.
  - o_timeout clears on the next detected edge (the arming edge).
- Match rule, evaluated on the measured count in the cycle of the edge:
  - diff = |counter - i_cnt_th|, unsigned CNT_W subtraction of larger minus smaller;
  - o_match <= (diff <= i_tol);
  - updates together with o_half_period.
- Lock rule:
  - a 2-bit streak increments on each match, saturating at 2;
  - the streak clears on a mismatch, on timeout or on leaving MEASURE;
  - o_locked = (streak = 2).
- Disable: enable=0 in any state → IDLE next cycle.
  - On entering IDLE, o_valid, o_locked and o_timeout go to 0 and the counter goes to 0.
  - o_half_period and o_match are retained.
- Simultaneous events:
  - enable falling together with an edge: enable wins, with no o_valid.
  - Edge in the same cycle as counter = TIMEOUT: the edge wins and is measured normally.
- i_cnt_th and i_tol are sampled combinationally at the edge cycle. They must be held stable by the user while measuring.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles while i_toggle toggles → all outputs 0, no o_valid; release with enable=0 → outputs stay 0.
- Nominal: enable=1, i_cnt_th=10, i_tol=0, i_toggle flips every 10 cycles → first edge gives no valid; then each o_valid has o_half_period=10 and o_match=1; o_locked=1 after the 2nd valid.
- Out of tolerance: from locked, change the period to 12 with i_cnt_th=10, i_tol=1 → next valid has o_half_period=12, o_match=0, o_locked falls; period 11 → o_match=1, with relock after two.
- Timeout: TIMEOUT=50, stop toggling → o_timeout=1 exactly 50 cycles after the last counted edge, o_locked=0. Resume toggling every 10 → o_timeout clears on the first edge without valid; the next valid reports 10.
- Disable mid-measure: drop enable 5 cycles after an edge, also once in the same cycle as a detected edge → no o_valid; o_locked/o_timeout=0; o_half_period retained. Re-enable → arming edge required before the next valid.
- Saturation: CNT_W=4, TIMEOUT=20, slow toggle → counter saturates at 15, o_timeout never asserts, reported o_half_period=15.
